instr_encoder: RTL and testbench
================================

# instr_encoder

Encoder counterpart of the datapath's instruction decoder. It accepts symbolic operation requests (op, registers, offset) over a valid/ready handshake and assembles 32-bit LEGv8 instruction words (LDUR, STUR, ADD, SUB, AND, ORR). Words are buffered in a small FIFO and each is tagged with a sequential byte address on the way out to the instruction-memory loader. Test benches and the program loader use it to fill instruction memory without hand-assembled hex.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 8, width of the output byte address.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush; empties the FIFO and zeroes the address.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept the request.
- req_op  in  3  0=LDUR, 1=STUR, 2=ADD, 3=SUB, 4=AND, 5=ORR, 6–7 illegal.
- req_rd  in  5  Rd for R-type; Rt for LDUR/STUR.
- req_rn  in  5  Rn, the base register for D-type.
- req_rm  in  5  Rm; ignored for D-type.
- req_addr  in  9  DT_address; ignored for R-type.
- out_valid  out  1  encoded word available.
- out_ready  in  1  loader accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  AW  byte address for out_instr.
- err  out  1  illegal-op indication (see Configuration).
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Opcode field [31:21]:
  - LDUR 11111000010
  - STUR 11111000000
  - ADD 10001011000
  - SUB 11001011000
  - AND 10001010000
  - ORR 10101010000
- R-type word: {opcode, Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0]}.
- D-type word: {opcode, DT_address[20:12], op2[11:10]=00, Rn[9:5], Rt[4:0]}.
- Push: req_valid && req_ready && legal op. The encoded word is written at the FIFO tail.
- Illegal op with req_valid && req_ready:
  - The request is consumed.
  - Nothing is pushed.
  - err behaves as described in Configuration.
- Pop: out_valid && out_ready. The head entry is removed and the address register increments by 4.
- Address behaviour:
  - out_addr always equals the address register.
  - It increments only on pop.
  - It wraps from 2^AW−4 to 0.
- req_ready = (count < DEPTH) && !clr. A full FIFO does not accept a request, even when a pop happens in the same cycle.
- Simultaneous push and pop: count is unchanged, both pointers advance and data ordering is preserved.
- out_valid = (count != 0). out_instr is the head entry, driven combinationally from the FIFO storage.
- clr has priority over push and pop in the same cycle. It resets the pointers, count and address, and clears err.

## Timing
- Reset values: req_ready=1, out_valid=0, out_instr=0, out_addr=0, count=0, err=0, pointers=0.
- reset is asynchronous: all state clears immediately, mid-transfer included. Any in-flight words are discarded.
- Latency: a request accepted at edge N appears as out_valid=1 after edge N; it is poppable at edge N+1 at the earliest. There is no combinational path from req to out.
- Throughput: one push and one pop per cycle when 0 < count < DEPTH.
- req_ready depends only on registered count and clr; there is no path from out_ready to req_ready.
- out_valid, out_instr and out_addr hold stable while out_valid && !out_ready.
- Empty FIFO with out_ready=1: no pop and no address change.

## Configuration
- INSTR_ENC_ILLEGAL_TRAP_EN:
  - Defined: an illegal op sets err and it stays set (sticky) until clr or reset. While err=1, req_ready=0 and all further requests are refused. The loader can still drain the FIFO.
  - Undefined: err is a one-cycle pulse in the cycle after the illegal request is consumed. Encoding continues normally, and the illegal request is silently dropped.

## Test plan
- After reset, push ADD (rd=3, rn=1, rm=2) -> out_instr=0x8B020023, out_addr=0x00. Pop it -> out_addr becomes 0x04.
- Push LDUR (rd=5, rn=2, addr=8), then STUR (rd=7, rn=0, addr=0), then SUB (rd=1, rn=1, rm=1) -> pops in order give 0xF8408045 @0x00, 0xF8000007 @0x04, 0xCB010021 @0x08.
- Hold out_ready=0 and push 5 requests -> count=4, req_ready=0, fifth request waits. Raise out_ready -> fifth is accepted the cycle after the first pop, and order is preserved.
- Continuous push and pop with count=2 -> count stays at 2 and addresses increment by 4 every cycle. With AW=8, after 64 pops out_addr wraps from 0xFC to 0x00.
- req_op=6 -> no push. With the macro defined: err=1 sticky and req_ready=0 until clr. Without it: one-cycle err pulse, and the next ADD encodes normally.
- Assert reset asynchronously with count=3, then assert clr in a separate run -> count=0, out_valid=0 and out_addr=0 in both cases. With clr, the push requested in that same cycle is ignored.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: assembles LEGv8 LDUR/STUR/ADD/SUB/AND/ORR words from symbolic
// requests and buffers them in a DEPTH-entry FIFO. Each word leaves tagged with
// a sequential byte address for the instruction-memory loader.
//
// Optional build macro INSTR_ENC_ILLEGAL_TRAP_EN:
//   defined   - an illegal op latches err until clr/reset and blocks new requests
//   undefined - an illegal op gives a one-cycle err pulse and is dropped
//
// Handshake (both req_* and out_*): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds valid and its
// payload until that edge. ready never depends combinationally on valid, and
// the output side never depends combinationally on the request side.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [4:0]               req_rd,
    input  logic [4:0]               req_rn,
    input  logic [4:0]               req_rm,
    input  logic [8:0]               req_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [AW-1:0]            out_addr,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] addr_q;
    logic          err_q;
    logic [31:0]   word;
    logic          legal;
    logic          accept;
    logic          push;
    logic          pop;
    logic          illegal_acc;

    // Space check uses the registered count only, so out_ready cannot reach req_ready.
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
    assign req_ready = (count < CW'(DEPTH)) && !clr && !err_q;
`else
    assign req_ready = (count < CW'(DEPTH)) && !clr;
`endif

    assign legal       = (req_op <= 3'd5);
    assign accept      = req_valid && req_ready;
    assign push        = accept && legal;
    assign illegal_acc = accept && !legal;
    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;
    assign out_addr    = addr_q;
    assign err         = err_q;
    // Gated so an empty FIFO shows zero rather than stale storage.
    assign out_instr   = out_valid ? mem[rd_ptr] : 32'h0;

    // Assemble the instruction word for the current request.
    always_comb begin
        word = 32'h0;
        case (req_op)
            3'd0:    word = {OPC_LDUR, req_addr, 2'b00, req_rn, req_rd};
            3'd1:    word = {OPC_STUR, req_addr, 2'b00, req_rn, req_rd};
            3'd2:    word = {OPC_ADD, req_rm, 6'd0, req_rn, req_rd};
            3'd3:    word = {OPC_SUB, req_rm, 6'd0, req_rn, req_rd};
            3'd4:    word = {OPC_AND, req_rm, 6'd0, req_rn, req_rd};
            3'd5:    word = {OPC_ORR, req_rm, 6'd0, req_rn, req_rd};
            default: word = 32'h0;
        endcase
    end

    // FIFO storage; needs no reset because out_instr is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    // Pointers and occupancy; clr wins over any push/pop in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Byte address of the head word; advances by one word per pop and wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (clr) begin
            addr_q <= '0;
        end else if (pop) begin
            addr_q <= addr_q + AW'(4);
        end
    end

    // Illegal-op indication: sticky trap or single-cycle pulse depending on build.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (clr) begin
            err_q <= 1'b0;
        end else begin
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
            err_q <= err_q | illegal_acc;
`else
            err_q <= illegal_acc;
`endif
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors, a queue-based reference model
// checked every cycle, and hand-computed literal expectations.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 8;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          clr;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [4:0]    req_rd;
    logic [4:0]    req_rn;
    logic [4:0]    req_rm;
    logic [8:0]    req_addr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          err;
    logic [2:0]    count;

    instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm), .req_addr(req_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err), .count(count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]   exp_q[$];
    logic [AW-1:0] exp_addr;
    logic          exp_err;
    bit            chk_en;

    // Word value from the instruction format tables, built by field weights.
    function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rd,
                                        input logic [4:0] rn, input logic [4:0] rm,
                                        input logic [8:0] a);
        int unsigned opc [6];
        int unsigned w;
        opc = '{32'h7C2, 32'h7C0, 32'h458, 32'h658, 32'h450, 32'h550};
        w = opc[op] * 32'd2097152 + 32'(rn) * 32'd32 + 32'(rd);
        if (op < 3'd2) w = w + 32'(a) * 32'd4096;
        else           w = w + 32'(rm) * 32'd65536;
        return w;
    endfunction

    function automatic bit model_ready();
        return (exp_q.size() < DEPTH) && !clr && !(TRAP && exp_err);
    endfunction

    always @(posedge clk or posedge reset) begin : model_upd
        bit acc;
        bit pp;
        if (reset) begin
            exp_q.delete();
            exp_addr = '0;
            exp_err  = 1'b0;
        end else begin
            acc = req_valid && model_ready();
            pp  = (exp_q.size() != 0) && out_ready;
            if (clr) begin
                exp_q.delete();
                exp_addr = '0;
                exp_err  = 1'b0;
            end else begin
                if (pp) begin
                    void'(exp_q.pop_front());
                    exp_addr = exp_addr + 8'd4;
                end
                if (acc && req_op <= 3'd5)
                    exp_q.push_back(enc(req_op, req_rd, req_rn, req_rm, req_addr));
                if (TRAP) exp_err = exp_err | (acc && req_op > 3'd5);
                else      exp_err = acc && (req_op > 3'd5);
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (!reset && chk_en) begin
            check("count", 32'(count), 32'(exp_q.size()));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("out_addr", 32'(out_addr), 32'(exp_addr));
            check("req_ready", 32'(req_ready), 32'(model_ready()));
            check("err", 32'(err), 32'(exp_err));
            if (exp_q.size() != 0) check("out_instr", out_instr, exp_q[0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic v, input logic [2:0] op, input logic [4:0] rd,
                           input logic [4:0] rn, input logic [4:0] rm, input logic [8:0] a);
        req_valid = v;
        req_op    = op;
        req_rd    = rd;
        req_rn    = rn;
        req_rm    = rm;
        req_addr  = a;
    endtask

    task automatic push_wait(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                             input logic [4:0] rm, input logic [8:0] a);
        bit done;
        bit rdy;
        done = 1'b0;
        set_req(1'b1, op, rd, rn, rm, a);
        for (int i = 0; i < 20 && !done; i++) begin
            rdy = req_ready;
            tick();
            if (rdy) done = 1'b1;
        end
        req_valid = 1'b0;
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1; clr = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        #7;
        reset = 1'b0;
        tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; clr = 1'b0; out_ready = 1'b0; chk_en = 1'b0;
        set_req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 9'd0);
        #3;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        #9;
        reset = 1'b0;
        tick();
        chk_en = 1'b1;

        // Single ADD then pop.
        push_wait(3'd2, 5'd3, 5'd1, 5'd2, 9'd0);
        check("add_word", out_instr, 32'h8B020023);
        check("add_addr", 32'(out_addr), 32'h00);
        out_ready = 1'b1;
        tick();
        check("add_pop_addr", 32'(out_addr), 32'h04);
        check("add_pop_valid", 32'(out_valid), 32'd0);

        // LDUR, STUR, SUB in order from a fresh reset.
        do_reset();
        push_wait(3'd0, 5'd5, 5'd2, 5'd0, 9'd8);
        push_wait(3'd1, 5'd7, 5'd0, 5'd0, 9'd0);
        push_wait(3'd3, 5'd1, 5'd1, 5'd1, 9'd0);
        check("seq_count", 32'(count), 32'd3);
        out_ready = 1'b1;
        check("ldur_word", out_instr, 32'hF8408045);
        check("ldur_addr", 32'(out_addr), 32'h00);
        tick();
        check("stur_word", out_instr, 32'hF8000007);
        check("stur_addr", 32'(out_addr), 32'h04);
        tick();
        check("sub_word", out_instr, 32'hCB010021);
        check("sub_addr", 32'(out_addr), 32'h08);
        tick();
        check("seq_empty", 32'(out_valid), 32'd0);
        check("seq_addr_end", 32'(out_addr), 32'h0C);

        // Full FIFO back-pressure with a fifth pending request.
        do_reset();
        push_wait(3'd2, 5'd3, 5'd1, 5'd2, 9'd0);
        push_wait(3'd5, 5'd4, 5'd5, 5'd6, 9'd0);
        push_wait(3'd4, 5'd7, 5'd8, 5'd9, 9'd0);
        push_wait(3'd0, 5'd1, 5'd2, 5'd0, 9'h1FF);
        set_req(1'b1, 3'd1, 5'd31, 5'd31, 5'd0, 9'd3);
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(req_ready), 32'd0);
        check("full_head", out_instr, 32'h8B020023);
        tick();
        check("full_wait_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        tick();
        check("after_pop_count", 32'(count), 32'd3);
        check("after_pop_ready", 32'(req_ready), 32'd1);
        check("orr_word", out_instr, 32'hAA0600A4);
        tick();
        req_valid = 1'b0;
        check("fifth_in_count", 32'(count), 32'd3);
        check("and_word", out_instr, 32'h8A090107);
        tick();
        check("ldur_max_word", out_instr, 32'hF85FF041);
        tick();
        check("stur_word2", out_instr, 32'hF80033FF);
        tick();
        check("drain_empty", 32'(out_valid), 32'd0);

        // Streaming at count=2 across the address wrap.
        do_reset();
        push_wait(3'd2, 5'd0, 5'd1, 5'd2, 9'd0);
        push_wait(3'd3, 5'd1, 5'd2, 5'd3, 9'd0);
        out_ready = 1'b1;
        set_req(1'b1, 3'd4, 5'd2, 5'd3, 5'd4, 9'd0);
        for (int i = 0; i < 64; i++) begin
            tick();
            req_rd = 5'(i + 3);
            req_op = 3'(2 + (i % 4));
        end
        req_valid = 1'b0;
        check("wrap_addr", 32'(out_addr), 32'h00);
        check("stream_count", 32'(count), 32'd2);
        tick();
        tick();
        check("stream_drained", 32'(count), 32'd0);

        // Illegal op.
        do_reset();
        set_req(1'b1, 3'd6, 5'd1, 5'd1, 5'd1, 9'd0);
        tick();
        req_valid = 1'b0;
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_nopush", 32'(count), 32'd0);
        if (TRAP) begin
            check("trap_ready", 32'(req_ready), 32'd0);
            set_req(1'b1, 3'd2, 5'd3, 5'd1, 5'd2, 9'd0);
            tick();
            tick();
            req_valid = 1'b0;
            check("trap_sticky", 32'(err), 32'd1);
            check("trap_refused", 32'(count), 32'd0);
            clr = 1'b1;
            tick();
            clr = 1'b0;
            check("trap_clr_err", 32'(err), 32'd0);
            check("trap_clr_ready", 32'(req_ready), 32'd1);
        end else begin
            tick();
            check("pulse_err_low", 32'(err), 32'd0);
            push_wait(3'd2, 5'd3, 5'd1, 5'd2, 9'd0);
            check("post_illegal_word", out_instr, 32'h8B020023);
            out_ready = 1'b1;
            tick();
            check("post_illegal_drain", 32'(count), 32'd0);
        end

        // Asynchronous reset with count=3.
        do_reset();
        out_ready = 1'b1;
        push_wait(3'd2, 5'd3, 5'd1, 5'd2, 9'd0);
        tick();
        out_ready = 1'b0;
        push_wait(3'd2, 5'd4, 5'd1, 5'd2, 9'd0);
        push_wait(3'd3, 5'd5, 5'd1, 5'd2, 9'd0);
        push_wait(3'd4, 5'd6, 5'd1, 5'd2, 9'd0);
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_addr", 32'(out_addr), 32'h04);
        #1;
        reset = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_addr", 32'(out_addr), 32'd0);
        #5;
        reset = 1'b0;
        tick();

        // Synchronous clr with count=3 and a push in the same cycle.
        out_ready = 1'b1;
        push_wait(3'd2, 5'd3, 5'd1, 5'd2, 9'd0);
        tick();
        out_ready = 1'b0;
        push_wait(3'd2, 5'd4, 5'd1, 5'd2, 9'd0);
        push_wait(3'd3, 5'd5, 5'd1, 5'd2, 9'd0);
        push_wait(3'd4, 5'd6, 5'd1, 5'd2, 9'd0);
        check("pre_clr_count", 32'(count), 32'd3);
        clr = 1'b1;
        set_req(1'b1, 3'd2, 5'd9, 5'd1, 5'd2, 9'd0);
        tick();
        clr = 1'b0;
        req_valid = 1'b0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_addr", 32'(out_addr), 32'd0);
        tick();
        check("clr_push_ignored", 32'(count), 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
